// File: rtl/iic_pkg.sv
// Shared I2C definitions: responder state encoding, bus ACK/NACK levels and defaults.
// Used by iic_slave and iic_master.
package iic_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_DEV_ADDR,
        ST_DEV_ACK,
        ST_REG_ADDR,
        ST_REG_ACK,
        ST_WR_DATA,
        ST_WR_ACK,
        ST_RD_DATA,
        ST_RD_ACK,
        ST_IGNORE
    } iic_state_t;

    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

    localparam logic [6:0] IIC_DEF_SLV_ADDR = 7'h3C;
    localparam int         IIC_DEF_FILT     = 3;

endpackage

// File: rtl/iic_line_filter.sv
// Pad input conditioning for one I2C line: 2-flop synchronizer, FILT-sample
// stability filter and single-cycle rise/fall pulses aligned with the level change.
module iic_line_filter #(
    parameter int FILT = 3
) (
    input  logic clk_i,
    input  logic rst_n,
    input  logic i_line,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    localparam int CW = $clog2(FILT) + 1;

    logic [1:0]    r_sync;
    logic          r_level;
    logic [CW-1:0] r_cnt;
    logic          r_rise;
    logic          r_fall;

    // NOTE: presetting to 1 (idle bus level) keeps reset release from looking like a START.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_sync  <= 2'b11;
            r_level <= 1'b1;
            r_cnt   <= '0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], i_line};
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            if (r_sync[1] != r_level) begin
                if (r_cnt == CW'(FILT - 1)) begin
                    r_level <= r_sync[1];
                    r_cnt   <= '0;
                    r_rise  <= r_sync[1];
                    r_fall  <= ~r_sync[1];
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_level = r_level;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;

endmodule

// File: rtl/iic_slave.sv
// I2C register-device responder: address match + ACK, register pointer byte,
// auto-incrementing writes and reads into an external 8-bit register space.
module iic_slave
    import iic_pkg::*;
#(
    parameter logic [6:0] SLV_ADDR = IIC_DEF_SLV_ADDR,
    parameter int         FILT     = IIC_DEF_FILT
) (
    input  logic       clk_i,
    input  logic       rst_n,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe_o,
    output logic [7:0] reg_addr_o,
    output logic [7:0] reg_wdata_o,
    output logic       reg_we_o,
    input  logic [7:0] reg_rdata_i,
    output logic       busy_o
);

    logic w_scl_lvl, w_scl_rise, w_scl_fall;
    logic w_sda_lvl, w_sda_rise, w_sda_fall;

    iic_line_filter #(.FILT(FILT)) u_scl_filt (
        .clk_i  (clk_i),
        .rst_n  (rst_n),
        .i_line (scl_i),
        .o_level(w_scl_lvl),
        .o_rise (w_scl_rise),
        .o_fall (w_scl_fall)
    );

    iic_line_filter #(.FILT(FILT)) u_sda_filt (
        .clk_i  (clk_i),
        .rst_n  (rst_n),
        .i_line (sda_i),
        .o_level(w_sda_lvl),
        .o_rise (w_sda_rise),
        .o_fall (w_sda_fall)
    );

    iic_state_t r_state;
    logic [3:0] r_cnt;
    logic [7:0] r_shreg;
    logic       r_rw;
    logic       r_phase;   // ACK states: ACK driven; RD_ACK: master ACKed
    logic       r_sda_oe;
    logic [7:0] r_reg_addr;
    logic [7:0] r_reg_wdata;
    logic       r_reg_we;
    logic       r_busy;

    logic       w_start, w_stop, w_last;
    logic [7:0] w_byte;

    assign w_start = w_sda_fall & w_scl_lvl;
    assign w_stop  = w_sda_rise & w_scl_lvl;
    assign w_byte  = {r_shreg[6:0], w_sda_lvl};
    assign w_last  = (r_cnt == 4'd7);

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_shreg     <= '0;
            r_rw        <= 1'b0;
            r_phase     <= 1'b0;
            r_sda_oe    <= 1'b0;
            r_reg_addr  <= '0;
            r_reg_wdata <= '0;
            r_reg_we    <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_reg_we <= 1'b0;
            if (r_reg_we)
                r_reg_addr <= r_reg_addr + 8'd1;

            if (w_start) begin
                r_state  <= ST_DEV_ADDR;
                r_cnt    <= '0;
                r_phase  <= 1'b0;
                r_sda_oe <= 1'b0;
                r_busy   <= 1'b1;
            end else if (w_stop) begin
                r_state  <= ST_IDLE;
                r_phase  <= 1'b0;
                r_sda_oe <= 1'b0;
                r_busy   <= 1'b0;
            end else begin
                case (r_state)
                    ST_DEV_ADDR, ST_REG_ADDR, ST_WR_DATA: begin
                        if (w_scl_rise) begin
                            r_shreg <= w_byte;
                            r_cnt   <= r_cnt + 4'd1;
                            if (w_last) begin
                                r_cnt <= '0;
                                if (r_state == ST_DEV_ADDR) begin
                                    r_rw    <= w_byte[0];
                                    r_state <= (w_byte[7:1] == SLV_ADDR) ? ST_DEV_ACK : ST_IGNORE;
                                end else if (r_state == ST_REG_ADDR) begin
                                    r_reg_addr <= w_byte;
                                    r_state    <= ST_REG_ACK;
                                end else begin
                                    r_reg_wdata <= w_byte;
                                    r_reg_we    <= 1'b1;
                                    r_state     <= ST_WR_ACK;
                                end
                            end
                        end
                    end

                    ST_DEV_ACK, ST_REG_ACK, ST_WR_ACK: begin
                        if (w_scl_fall) begin
                            if (!r_phase) begin
                                r_sda_oe <= ~ACK;
                                r_phase  <= 1'b1;
                            end else begin
                                r_sda_oe <= 1'b0;
                                r_phase  <= 1'b0;
                                r_cnt    <= '0;
                                if (r_state == ST_DEV_ACK && r_rw) begin
                                    // First read byte goes out on the same fall that ends the ACK
                                    r_shreg  <= reg_rdata_i;
                                    r_sda_oe <= ~reg_rdata_i[7];
                                    r_state  <= ST_RD_DATA;
                                end else begin
                                    r_state <= (r_state == ST_DEV_ACK) ? ST_REG_ADDR : ST_WR_DATA;
                                end
                            end
                        end
                    end

                    ST_RD_DATA: begin
                        if (w_scl_rise) begin
                            r_cnt <= r_cnt + 4'd1;
                        end else if (w_scl_fall) begin
                            if (r_cnt == 4'd8) begin
                                r_sda_oe <= 1'b0;
                                r_cnt    <= '0;
                                r_phase  <= 1'b0;
                                r_state  <= ST_RD_ACK;
                            end else begin
                                r_shreg  <= {r_shreg[6:0], 1'b0};
                                r_sda_oe <= ~r_shreg[6];
                            end
                        end
                    end

                    ST_RD_ACK: begin
                        if (w_scl_rise && !r_phase) begin
                            // The pointer moves past every byte handed out, ACKed or not
                            r_reg_addr <= r_reg_addr + 8'd1;
                            if (w_sda_lvl == ACK)
                                r_phase <= 1'b1;
                            else
                                r_state <= ST_IGNORE;
                        end else if (w_scl_fall && r_phase) begin
                            r_shreg  <= reg_rdata_i;
                            r_sda_oe <= ~reg_rdata_i[7];
                            r_phase  <= 1'b0;
                            r_cnt    <= '0;
                            r_state  <= ST_RD_DATA;
                        end
                    end

                    default: ;
                endcase
            end
        end
    end

    assign sda_oe_o    = r_sda_oe;
    assign reg_addr_o  = r_reg_addr;
    assign reg_wdata_o = r_reg_wdata;
    assign reg_we_o    = r_reg_we;
    assign busy_o      = r_busy;

endmodule

// File: tb/tb_iic_slave.sv
// Directed bench for iic_slave: the bench plays the I2C master and the register space.
module tb_iic_slave;

    localparam int Q = 20;

    logic       clk_i = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_oe_o;
    logic [7:0] reg_addr_o;
    logic [7:0] reg_wdata_o;
    logic       reg_we_o;
    logic [7:0] reg_rdata_i;
    logic       busy_o;
    logic       sda_bus;

    logic [7:0] mem [256];
    logic [7:0] we_addr_q [$];
    logic [7:0] we_data_q [$];
    int         oe_cycles = 0;
    int         n_chk = 0;
    int         n_bad = 0;

    always #5 clk_i = ~clk_i;

    assign sda_bus     = sda_m & ~sda_oe_o;
    assign reg_rdata_i = mem[reg_addr_o];

    iic_slave #(.SLV_ADDR(7'h3C), .FILT(3)) dut (
        .clk_i      (clk_i),
        .rst_n      (rst_n),
        .scl_i      (scl_m),
        .sda_i      (sda_bus),
        .sda_oe_o   (sda_oe_o),
        .reg_addr_o (reg_addr_o),
        .reg_wdata_o(reg_wdata_o),
        .reg_we_o   (reg_we_o),
        .reg_rdata_i(reg_rdata_i),
        .busy_o     (busy_o)
    );

    always @(negedge clk_i) begin
        if (reg_we_o) begin
            we_addr_q.push_back(reg_addr_o);
            we_data_q.push_back(reg_wdata_o);
        end
        if (sda_oe_o)
            oe_cycles++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic check_wr(input string tag, input int idx, input logic [7:0] a, input logic [7:0] d);
        if (we_addr_q.size() > idx) begin
            check({tag, "_addr"}, we_addr_q[idx], a);
            check({tag, "_data"}, we_data_q[idx], d);
        end else begin
            check({tag, "_present"}, we_addr_q.size(), idx + 1);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic bus_start();
        sda_m = 1'b1; step(Q);
        scl_m = 1'b1; step(Q);
        sda_m = 1'b0; step(Q);
        scl_m = 1'b0; step(Q);
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; step(Q);
        scl_m = 1'b1; step(Q);
        sda_m = 1'b1; step(Q);
    endtask

    task automatic send_bit(input logic b);
        sda_m = b;    step(Q);
        scl_m = 1'b1; step(2 * Q);
        scl_m = 1'b0; step(Q);
    endtask

    task automatic read_bit(output logic b);
        sda_m = 1'b1; step(Q);
        scl_m = 1'b1; step(Q);
        b = sda_bus;  step(Q);
        scl_m = 1'b0; step(Q);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        read_bit(ack);
    endtask

    task automatic read_byte(output logic [7:0] d, input logic mack);
        for (int i = 7; i >= 0; i--) read_bit(d[i]);
        send_bit(mack);
    endtask

    initial begin
        logic       ack;
        logic [7:0] rd;
        int         wbase;
        int         obase;

        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h20] = 8'h81;
        mem[8'h21] = 8'h7E;

        step(4);
        check("rst_sda_oe", sda_oe_o, 1'b0);
        check("rst_we", reg_we_o, 1'b0);
        check("rst_addr", reg_addr_o, 8'h00);
        check("rst_wdata", reg_wdata_o, 8'h00);
        check("rst_busy", busy_o, 1'b0);
        rst_n = 1'b1;
        step(10);

        // Plain write of two bytes at 10/11
        wbase = we_addr_q.size();
        bus_start();
        check("w1_busy_start", busy_o, 1'b1);
        write_byte(8'h78, ack); check("w1_ack_dev", ack, 1'b0);
        write_byte(8'h10, ack); check("w1_ack_reg", ack, 1'b0);
        write_byte(8'hA5, ack); check("w1_ack_d0", ack, 1'b0);
        write_byte(8'h5A, ack); check("w1_ack_d1", ack, 1'b0);
        check("w1_busy_pre_stop", busy_o, 1'b1);
        bus_stop();
        check("w1_busy_stop", busy_o, 1'b0);
        check("w1_wr_count", we_addr_q.size() - wbase, 2);
        check_wr("w1_wr0", wbase, 8'h10, 8'hA5);
        check_wr("w1_wr1", wbase + 1, 8'h11, 8'h5A);
        check("w1_addr_after", reg_addr_o, 8'h12);

        // Pointer write, repeated START, read with ACK then NACK
        wbase = we_addr_q.size();
        bus_start();
        write_byte(8'h78, ack); check("r_ack_dev_w", ack, 1'b0);
        write_byte(8'h20, ack); check("r_ack_reg", ack, 1'b0);
        bus_start();
        write_byte(8'h79, ack); check("r_ack_dev_r", ack, 1'b0);
        read_byte(rd, 1'b0);    check("r_byte0", rd, 8'h81);
        read_byte(rd, 1'b1);    check("r_byte1", rd, 8'h7E);
        check("r_sda_released", sda_oe_o, 1'b0);
        check("r_addr_after", reg_addr_o, 8'h22);
        bus_stop();
        check("r_no_writes", we_addr_q.size() - wbase, 0);

        // Wrong address: never pulled, no write; the right address still answers
        wbase = we_addr_q.size();
        obase = oe_cycles;
        bus_start();
        write_byte(8'h7A, ack); check("na_ack_dev", ack, 1'b1);
        write_byte(8'h55, ack); check("na_ack_data", ack, 1'b1);
        bus_stop();
        check("na_oe_cycles", oe_cycles - obase, 0);
        check("na_no_writes", we_addr_q.size() - wbase, 0);
        bus_start();
        write_byte(8'h78, ack); check("na2_ack_dev", ack, 1'b0);
        write_byte(8'h30, ack); check("na2_ack_reg", ack, 1'b0);
        write_byte(8'h44, ack); check("na2_ack_d0", ack, 1'b0);
        bus_stop();
        check_wr("na2_wr0", wbase, 8'h30, 8'h44);

        // Auto-increment wraps FF -> 00
        wbase = we_addr_q.size();
        bus_start();
        write_byte(8'h78, ack);
        write_byte(8'hFF, ack);
        write_byte(8'h11, ack); check("wrap_ack_d0", ack, 1'b0);
        write_byte(8'h22, ack); check("wrap_ack_d1", ack, 1'b0);
        bus_stop();
        check_wr("wrap_wr0", wbase, 8'hFF, 8'h11);
        check_wr("wrap_wr1", wbase + 1, 8'h00, 8'h22);
        check("wrap_addr_after", reg_addr_o, 8'h01);

        // SCL glitches of 1 and 2 cycles are rejected
        bus_start();
        sda_m = 1'b0;
        scl_m = 1'b1; step(1); scl_m = 1'b0; step(10);
        scl_m = 1'b1; step(2); scl_m = 1'b0; step(10);
        write_byte(8'h78, ack); check("glitch_reject_ack", ack, 1'b0);
        bus_stop();

        // A 3-cycle pulse is a real clock: the address shifts by one bit and misses
        bus_start();
        sda_m = 1'b0;
        scl_m = 1'b1; step(3); scl_m = 1'b0; step(10);
        write_byte(8'h78, ack); check("glitch_accept_ack", ack, 1'b1);
        bus_stop();

        // Reset while the slave drives a 0 read bit
        bus_start();
        write_byte(8'h78, ack);
        write_byte(8'h40, ack);
        bus_start();
        write_byte(8'h79, ack); check("rst_mid_ack", ack, 1'b0);
        check("rst_mid_driving", sda_oe_o, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_oe", sda_oe_o, 1'b0);
        check("rst_mid_busy", busy_o, 1'b0);
        check("rst_mid_addr", reg_addr_o, 8'h00);
        step(3);
        rst_n = 1'b1;
        obase = oe_cycles;
        read_byte(rd, 1'b1);
        check("post_rst_oe_cycles", oe_cycles - obase, 0);
        check("post_rst_busy", busy_o, 1'b0);
        bus_stop();
        wbase = we_addr_q.size();
        bus_start();
        write_byte(8'h78, ack); check("post_rst_ack_dev", ack, 1'b0);
        write_byte(8'h50, ack);
        write_byte(8'h66, ack); check("post_rst_ack_d0", ack, 1'b0);
        bus_stop();
        check_wr("post_rst_wr0", wbase, 8'h50, 8'h66);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
